// File: rtl/win_pkg.sv
// -----------------------------------------------------------------------------
// win_pkg
// Shared definitions for the parametrised sliding-window controller:
//   - state_t   : FSM state encoding (3 bits)
//   - cnt_w()   : bits needed to hold a counter ranging over 0..n-1
// -----------------------------------------------------------------------------
package win_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      FILL   = 3'd2,
      OUT    = 3'd3,
      GAP_ST = 3'd4,
      FINISH = 3'd5,
      DONE   = 3'd6
   } state_t;

   // Width of a counter that takes the values 0..n-1 (never narrower than 1).
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/win_pos_counter.sv
// -----------------------------------------------------------------------------
// win_pos_counter
// Column/row position counter for the pixel stream entering the window.
// The column counter steps on every accepted column and wraps at IMG_W-1,
// advancing the row counter. Rows count window top-rows, 0..IMG_H-K, and wrap
// back to 0 after the last output row.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear of both counters (frame start)
//   inc           one column accepted this cycle
//   col_cnt       current column index of the next column to be accepted
//   row_cnt       current window top-row index
//   col_eq_max    col_cnt == IMG_W-1 (next accept ends the row)
//   col_ge_km1    col_cnt >= K-1     (next accept completes a window)
//   row_eq_last   row_cnt == IMG_H-K (streaming the last output row)
// -----------------------------------------------------------------------------
module win_pos_counter
   import win_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 15,
   parameter int CW    = cnt_w(IMG_W),
   parameter int RW    = cnt_w(IMG_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] col_cnt,
   output logic [RW-1:0] row_cnt,
   output logic          col_eq_max,
   output logic          col_ge_km1,
   output logic          row_eq_last
);

   assign col_eq_max  = (col_cnt == CW'(IMG_W - 1));
   assign col_ge_km1  = (col_cnt >= CW'(K - 1));
   assign row_eq_last = (row_cnt == RW'(IMG_H - K));

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would make results depend on block order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (inc) begin
         if (col_eq_max) begin
            col_cnt <= '0;
            row_cnt <= row_eq_last ? '0 : row_cnt + 1'b1;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/window_buffer_ctrl_param.sv
// -----------------------------------------------------------------------------
// window_buffer_ctrl_param
// Control FSM for a KxK sliding-window register fed by K-1 line buffers.
// Accepts pixel columns from the line-buffer bank, tracks the window position,
// presents completed windows to a downstream consumer with ready/valid
// back-pressure, inserts GAP idle cycles between rows and pulses
// progress_done once the last window of the frame has been consumed.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   done_i         line buffers primed; starts a frame (sampled in IDLE only)
//   valid_i        a new pixel column is available
//   ready_i        consumer accepts the presented window
//   shift_en       column accepted; window registers shift this cycle
//   valid_o        a complete KxK window is presented
//   col_o, row_o   left column / top row of the presented window
//   eol_o, eof_o   presented window is last of its row / of the frame
//   progress_done  one-cycle pulse when the frame is complete
// -----------------------------------------------------------------------------
module window_buffer_ctrl_param
   import win_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 15,
   parameter int GAP   = 2,
   parameter int CW    = cnt_w(IMG_W),
   parameter int RW    = cnt_w(IMG_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          done_i,
   input  logic          valid_i,
   input  logic          ready_i,
   output logic          shift_en,
   output logic          valid_o,
   output logic [CW-1:0] col_o,
   output logic [RW-1:0] row_o,
   output logic          eol_o,
   output logic          eof_o,
   output logic          progress_done
);

   generate
      if ((K % 2) == 0 || K < 3) begin : g_bad_k
         $error("window_buffer_ctrl_param: K must be odd and >= 3");
      end
      if (K > IMG_W || K > IMG_H) begin : g_bad_size
         $error("window_buffer_ctrl_param: K must not exceed IMG_W or IMG_H");
      end
      if (GAP < 0) begin : g_bad_gap
         $error("window_buffer_ctrl_param: GAP must be >= 0");
      end
   endgenerate

   localparam int GW       = cnt_w(GAP);
   localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   state_t        state;
   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   logic          col_eq_max;
   logic          col_ge_km1;
   logic          row_eq_last;
   logic [GW-1:0] gap_cnt;
   logic          stall;
   logic          gap_expired;

   // A presented window that the consumer refuses blocks any further shift,
   // otherwise the held window would be overwritten.
   assign stall       = valid_o & ~ready_i;
   assign shift_en    = valid_i & ~stall & ((state == FILL) | (state == OUT));
   // With GAP==0 the counter sits at 0, so the gap counts as expired at once.
   assign gap_expired = (gap_cnt == GW'(GAP_LAST));

   win_pos_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .K     (K),
      .CW    (CW),
      .RW    (RW)
   ) u_pos (
      .clk         (clk),
      .rst         (rst),
      .clr         (state == START),
      .inc         (shift_en),
      .col_cnt     (col_cnt),
      .row_cnt     (row_cnt),
      .col_eq_max  (col_eq_max),
      .col_ge_km1  (col_ge_km1),
      .row_eq_last (row_eq_last)
   );

   // Frame sequencing FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         gap_cnt       <= '0;
         progress_done <= 1'b0;
      end else begin
         progress_done <= 1'b0;
         case (state)
            IDLE:   if (done_i) state <= START;
            START:  state <= FILL;
            // Leave FILL once the accepted column brings col_cnt to K-1.
            FILL:   if (shift_en && col_cnt == CW'(K - 2)) state <= OUT;
            OUT: begin
               if (shift_en && col_eq_max) begin
                  gap_cnt <= '0;
                  // The last row always parks in GAP_ST to await the eof handshake.
                  state   <= (row_eq_last || GAP != 0) ? GAP_ST : FILL;
               end
            end
            GAP_ST: begin
               if (!gap_expired) gap_cnt <= gap_cnt + 1'b1;
               if (valid_o && eof_o) begin
                  if (ready_i) begin
                     state         <= FINISH;
                     progress_done <= 1'b1;
                  end
               end else if (gap_expired && (!valid_o || ready_i)) begin
                  state <= FILL;
               end
            end
            FINISH: state <= DONE;
            DONE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Presented-window register: loads on a window-completing accept, holds
   // while stalled, drops after the consumer takes it with no replacement.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_o <= 1'b0;
         col_o   <= '0;
         row_o   <= '0;
         eol_o   <= 1'b0;
         eof_o   <= 1'b0;
      end else if (shift_en && col_ge_km1) begin
         valid_o <= 1'b1;
         col_o   <= col_cnt - CW'(K - 1);
         row_o   <= row_cnt;
         eol_o   <= col_eq_max;
         eof_o   <= col_eq_max & row_eq_last;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule
